mem_access_unit: RTL and testbench

Memory-stage access unit for the five-stage ARM pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its control outputs (size, enable, rw, load, rf) together with the ALU address, store data and destination register. It runs a multi-cycle request/acknowledge transaction to data RAM and holds the pipeline with a stall until the access completes. It then presents the load data or ALU result, with the qualified register-file write, to the MEM/WB register.

---
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: request/ack transaction to data RAM with pipeline stall.
// Optional alignment fault detection for word accesses is enabled by MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              size_i,
  input  logic              enable_i,
  input  logic              rw_i,
  input  logic              load_i,
  input  logic              rf_i,
  input  logic [31:0]       address_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        rd_i,
  output logic [31:0]       result_o,
  output logic              rf_o,
  output logic [3:0]        rd_o,
  output logic              stall_o,
  output logic              fault_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

  state_t      state_q, state_d;
  logic        size_q;
  logic [31:0] load_q;
  logic [31:0] lane_data;
  logic        misalign;
  logic        start;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (state_q == StIdle) & enable_i & size_i & (address_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign start    = (state_q == StIdle) & enable_i & ~misalign;
  assign stall_o  = start | (state_q == StWait);
  assign rf_o     = rf_i & ~stall_o & ~misalign;
  assign rd_o     = rd_i;
  assign result_o = misalign ? 32'h0 : (load_i ? load_q : address_i);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StWait;
      StWait:  if (mem_ack_i) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte lane is taken from the latched address; word accesses use the full word.
  always_comb begin
    lane_data = 32'h0;
    unique case (mem_addr_o[1:0])
      2'd0: lane_data = {24'h0, mem_rdata_i[7:0]};
      2'd1: lane_data = {24'h0, mem_rdata_i[15:8]};
      2'd2: lane_data = {24'h0, mem_rdata_i[23:16]};
      2'd3: lane_data = {24'h0, mem_rdata_i[31:24]};
      default: lane_data = 32'h0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= StIdle;
      size_q      <= 1'b0;
      load_q      <= 32'h0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= 4'h0;
      mem_wdata_o <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mem_req_o <= 1'b1;
        mem_we_o  <= rw_i;
        size_q    <= size_i;
        if (size_i) begin
          mem_addr_o  <= {address_i[ADDR_W-1:2], 2'b00};
          mem_be_o    <= 4'b1111;
          mem_wdata_o <= data_i;
        end else begin
          mem_addr_o  <= address_i[ADDR_W-1:0];
          mem_be_o    <= 4'b0001 << address_i[1:0];
          mem_wdata_o <= {4{data_i[7:0]}};
        end
      end
      if ((state_q == StWait) && mem_ack_i) begin
        mem_req_o <= 1'b0;
        load_q    <= size_q ? mem_rdata_i : lane_data;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge CLK) begin
    if (CLR) fault_q <= 1'b0;
    else     fault_q <= misalign;
  end
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected results queued at issue, checked in DONE.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        size_i, enable_i, rw_i, load_i, rf_i;
  logic [31:0] address_i, data_i;
  logic [3:0]  rd_i;
  logic [31:0] result_o;
  logic        rf_o, stall_o, fault_o;
  logic [3:0]  rd_o;
  logic        mem_req_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  mem_access_unit #(.ADDR_W(8)) dut (
    .CLK(CLK), .CLR(CLR), .size_i(size_i), .enable_i(enable_i), .rw_i(rw_i),
    .load_i(load_i), .rf_i(rf_i), .address_i(address_i), .data_i(data_i), .rd_i(rd_i),
    .result_o(result_o), .rf_o(rf_o), .rd_o(rd_o), .stall_o(stall_o), .fault_o(fault_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
  );

  function automatic logic [31:0] model_load(input logic sz, input logic [31:0] rd,
                                             input logic [1:0] a);
    if (sz) return rd;
    case (a)
      2'd0: return {24'h0, rd[7:0]};
      2'd1: return {24'h0, rd[15:8]};
      2'd2: return {24'h0, rd[23:16]};
      default: return {24'h0, rd[31:24]};
    endcase
  endfunction

  // Issues one memory op at posedge+1; acks in WAIT cycle ack_after; returns at posedge+1.
  task automatic run_op(input string name, input logic sz, input logic rw, input logic ld,
                        input logic rf, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int ack_after,
                        input logic [3:0] exp_be, input logic [7:0] exp_addr,
                        input logic [31:0] exp_wdata);
    logic [31:0] exp_res;
    int stalls;
    bit done;
    exp_q.push_back(ld ? model_load(sz, rdata, addr[1:0]) : addr);
    size_i = sz; rw_i = rw; load_i = ld; rf_i = rf; address_i = addr; data_i = data;
    rd_i = 4'h7; enable_i = 1'b1;
    stalls = 0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge CLK);
      mem_ack_i = 1'b0;
      if (stall_o) begin
        stalls++;
        if (c >= 1) begin
          checks++;
          if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
              {1'b1, rw, exp_be, exp_addr, exp_wdata}) begin
            failures++;
            $display("FAIL %s wait_bus c=%0d got req=%b we=%b be=%b addr=%h wdata=%h want req=1 we=%b be=%b addr=%h wdata=%h",
                     name, c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                     rw, exp_be, exp_addr, exp_wdata);
          end
          checks++;
          if (rf_o !== 1'b0) begin
            failures++;
            $display("FAIL %s bubble c=%0d got rf_o=%b want 0", name, c, rf_o);
          end
        end
        if (c == ack_after) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rdata;
        end
      end else begin
        done = 1;
        exp_res = exp_q.pop_front();
        checks++;
        if (result_o !== exp_res) begin
          failures++;
          $display("FAIL %s done_result got=%h want=%h", name, result_o, exp_res);
        end
        checks++;
        if ({rf_o, rd_o, mem_req_o} !== {rf, 4'h7, 1'b0}) begin
          failures++;
          $display("FAIL %s done_ctl got rf=%b rd=%h req=%b want rf=%b rd=7 req=0",
                   name, rf_o, rd_o, mem_req_o, rf);
        end
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout got no DONE within 64 cycles want DONE", name);
    end
    checks++;
    if (stalls != ack_after + 1) begin
      failures++;
      $display("FAIL %s stall_cycles got=%0d want=%0d", name, stalls, ack_after + 1);
    end
    @(posedge CLK); #1;
    enable_i = 1'b0; rf_i = 1'b0; load_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1; size_i = 0; enable_i = 0; rw_i = 0; load_i = 1; rf_i = 1;
    address_i = 32'h55; data_i = 0; rd_i = 4'h3; mem_rdata_i = 0; mem_ack_i = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, fault_o} !== '0) begin
      failures++;
      $display("FAIL reset_bus got req=%b we=%b be=%b addr=%h wdata=%h fault=%b want all 0",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, fault_o);
    end
    checks++;
    if ({stall_o, rf_o, rd_o, result_o} !== {1'b0, 1'b1, 4'h3, 32'h0}) begin
      failures++;
      $display("FAIL reset_out got stall=%b rf=%b rd=%h result=%h want stall=0 rf=1 rd=3 result=0",
               stall_o, rf_o, rd_o, result_o);
    end
    @(posedge CLK); #1;
    load_i = 0; rf_i = 0;
  endtask

  task automatic test_alu();
    enable_i = 0; rf_i = 1; load_i = 0; address_i = 32'h5;
    @(negedge CLK);
    checks++;
    if ({stall_o, rf_o, result_o} !== {1'b0, 1'b1, 32'h5}) begin
      failures++;
      $display("FAIL alu_pass got stall=%b rf=%b result=%h want stall=0 rf=1 result=5",
               stall_o, rf_o, result_o);
    end
    mem_ack_i = 1'b1;
    @(negedge CLK);
    mem_ack_i = 1'b0;
    @(negedge CLK);
    checks++;
    if ({stall_o, mem_req_o, rf_o} !== {1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL alu_spurious_ack got stall=%b req=%b rf=%b want stall=0 req=0 rf=1",
               stall_o, mem_req_o, rf_o);
    end
    @(posedge CLK); #1;
    rf_i = 0;
  endtask

  task automatic test_word_load();
    run_op("word_load", 1, 0, 1, 1, 32'h10, 32'hCAFEF00D, 32'hDEADBEEF, 3,
           4'b1111, 8'h10, 32'hCAFEF00D);
  endtask

  task automatic test_byte_load();
    run_op("byte_load", 0, 0, 1, 1, 32'h13, 32'h0, 32'hAABBCCDD, 1,
           4'b1000, 8'h13, 32'h0);
  endtask

  task automatic test_byte_store();
    run_op("byte_store", 0, 1, 0, 0, 32'h21, 32'h12345677, 32'h0, 2,
           4'b0010, 8'h21, 32'h77777777);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_store", 1, 1, 0, 0, 32'h30, 32'hA5A5A5A5, 32'h0, 2,
           4'b1111, 8'h30, 32'hA5A5A5A5);
    run_op("b2b_load", 0, 0, 1, 1, 32'h32, 32'h0, 32'h00FF1100, 1,
           4'b0100, 8'h32, 32'h0);
  endtask

  task automatic test_clr();
    size_i = 1; rw_i = 0; load_i = 1; rf_i = 1; address_i = 32'h40; enable_i = 1;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (mem_req_o !== 1'b1) begin
      failures++;
      $display("FAIL clr_pre_req got=%b want=1", mem_req_o);
    end
    CLR = 1'b1; enable_i = 1'b0;
    @(negedge CLK);
    CLR = 1'b0;
    checks++;
    if ({mem_req_o, stall_o} !== 2'b00) begin
      failures++;
      $display("FAIL clr_abort got req=%b stall=%b want req=0 stall=0", mem_req_o, stall_o);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
    @(negedge CLK);
    mem_ack_i = 1'b0;
    checks++;
    if ({stall_o, mem_req_o, rf_o, result_o} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL clr_late_ack got stall=%b req=%b rf=%b result=%h want stall=0 req=0 rf=1 result=0",
               stall_o, mem_req_o, rf_o, result_o);
    end
    @(posedge CLK); #1;
    load_i = 0; rf_i = 0;
  endtask

  task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
    size_i = 1; rw_i = 0; load_i = 1; rf_i = 1; address_i = 32'h22; enable_i = 1;
    @(negedge CLK);
    checks++;
    if ({stall_o, rf_o, result_o, mem_req_o, fault_o} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL align_detect got stall=%b rf=%b result=%h req=%b fault=%b want 0s",
               stall_o, rf_o, result_o, mem_req_o, fault_o);
    end
    @(posedge CLK); #1;
    enable_i = 0; rf_i = 0; load_i = 0;
    @(negedge CLK);
    checks++;
    if ({fault_o, mem_req_o} !== 2'b10) begin
      failures++;
      $display("FAIL align_pulse got fault=%b req=%b want fault=1 req=0", fault_o, mem_req_o);
    end
    @(negedge CLK);
    checks++;
    if (fault_o !== 1'b0) begin
      failures++;
      $display("FAIL align_pulse_end got fault=%b want 0", fault_o);
    end
    @(posedge CLK); #1;
`else
    run_op("align_word", 1, 0, 1, 1, 32'h22, 32'h0, 32'h11223344, 1,
           4'b1111, 8'h20, 32'h0);
    @(negedge CLK);
    checks++;
    if (fault_o !== 1'b0) begin
      failures++;
      $display("FAIL align_nofault got fault=%b want 0", fault_o);
    end
    @(posedge CLK); #1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_back_to_back();
    test_clr();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
